// File: rtl/iic_target.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// write-byte delivery and (with IIC_TARGET_READ_EN defined) host-fed read bytes.
module iic_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, WAIT_STOP
`ifdef IIC_TARGET_READ_EN
    , READ, READ_ACK
`endif
  } state_t;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       oe_d, rx_valid_d, tx_req_d, busy_d;
  logic [7:0] rx_data_d;
  logic [7:0] byte_in;
  logic       rw_ok;

`ifdef IIC_TARGET_READ_EN
  logic rw_q, rw_d;
  assign rw_ok = 1'b1;
`else
  wire unused_tx = ^tx_data;
  assign rw_ok = ~byte_in[0];
`endif

  // p0/p1 synchronize the raw pins, p2 holds the previous synchronized value
  always_ff @(posedge clk) begin
    scl_p0 <= scl_i;
    scl_p1 <= scl_p0;
    scl_p2 <= scl_p1;
    sda_p0 <= sda_i;
    sda_p1 <= sda_p0;
    sda_p2 <= sda_p1;
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
  assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
  assign byte_in   = {shift_q[6:0], sda_p1};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ack_d      = ack_q;
    oe_d       = sda_oe;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy;
`ifdef IIC_TARGET_READ_EN
    rw_d       = rw_q;
`endif
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR && rw_ok) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              ack_d   = 1'b0;
`ifdef IIC_TARGET_READ_EN
              rw_d    = byte_in[0];
`endif
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // ack_q marks that the ACK bit is being driven; the second fall ends it
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              cnt_d = 3'd0;
`ifdef IIC_TARGET_READ_EN
              if (rw_q) begin
                shift_d = tx_data;
                oe_d    = ~tx_data[7];
                state_d = READ;
              end else begin
                oe_d    = 1'b0;
                state_d = WRITE;
              end
`else
              oe_d    = 1'b0;
              state_d = WRITE;
`endif
            end
          end
`ifdef IIC_TARGET_READ_EN
          else if (scl_rise && ack_q && rw_q) begin
            tx_req_d = 1'b1;
          end
`endif
        end
        WRITE: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            ack_d      = 1'b0;
            state_d    = WRITE_ACK;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (!ack_q) begin
            oe_d  = 1'b1;
            ack_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            cnt_d   = 3'd0;
            state_d = WRITE;
          end
        end
`ifdef IIC_TARGET_READ_EN
        READ: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            state_d = READ_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
            cnt_d   = cnt_q + 3'd1;
          end
        end
        READ_ACK: begin
          if (scl_rise && !ack_q) begin
            if (!sda_p1) begin
              tx_req_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && ack_q) begin
            shift_d = tx_data;
            oe_d    = ~tx_data[7];
            cnt_d   = 3'd0;
            ack_d   = 1'b0;
            state_d = READ;
          end
        end
`endif
        WAIT_STOP: oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ack_q    <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
`ifdef IIC_TARGET_READ_EN
      rw_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      sda_oe   <= oe_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      tx_req   <= tx_req_d;
      busy     <= busy_d;
`ifdef IIC_TARGET_READ_EN
      rw_q     <= rw_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: doc/iic_target.md
# iic_target

Single-address I2C target (responder) for the same bus that `iic_controller` drives. Oversamples `scl`/`sda` in the system clock domain, detects START/STOP, matches a 7-bit address, ACKs and delivers written bytes to the host logic, and shifts out host-supplied bytes on reads. Open-drain: the block only ever pulls SDA low.

## Interface
- `SLAVE_ADDR`, 7'h42, 7-bit bus address this target answers to
- `clk` input 1, system clock, rising edge; must be ≥ 16× SCL frequency
- `rst` input 1, synchronous active-high reset
- `scl_i` input 1, raw bus SCL (asynchronous)
- `sda_i` input 1, raw bus SDA as resolved on the wire (asynchronous)
- `sda_oe` output 1, 1 = pull SDA low, 0 = release
- `rx_data` output 8, last byte written by the controller
- `rx_valid` output 1, one-cycle pulse: `rx_data` updated
- `tx_data` input 8, next byte to send on a read
- `tx_req` output 1, one-cycle pulse: host must present the next `tx_data`
- `busy` output 1, high from an address match until STOP/START or reset

## Operation
- `scl_i`, `sda_i` each pass through a 2-FF synchronizer plus one history register; edges are detected on the synchronized values.
- START: synchronized SDA 1→0 while SCL high. STOP: SDA 0→1 while SCL high. Both are recognized in every state and take priority over bit processing in the same cycle.
- Data is sampled on SCL rising edge, MSB first. `sda_oe` changes only on SCL falling edge (or on STOP/START/reset).
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- IDLE: START → ADDR, bit counter 0.
- ADDR: shift 8 bits. After the 8th rise: if bits[7:1] == `SLAVE_ADDR` and the R/W bit is supported → ADDR_ACK, `busy`=1; otherwise → WAIT_STOP (NACK; SDA untouched).
- ADDR_ACK: `sda_oe`=1 from the next SCL fall to the following SCL fall. For R/W=0 → WRITE. For R/W=1, `tx_req` pulses on the ACK-bit SCL rise; `tx_data` is captured into the shift register on the ACK-ending SCL fall, the MSB is driven, → READ.
- WRITE: shift 8 bits. On the 8th rise, `rx_data` ← byte; `rx_valid` pulses the next cycle; → WRITE_ACK (ACK always driven). After the ACK → WRITE.
- READ: each SCL fall drives the next bit (`sda_oe` = ~bit). After the 8th bit's fall, release → READ_ACK.
- READ_ACK: sample the controller's bit on SCL rise. 0 (ACK) → `tx_req` pulse, capture `tx_data` on the next fall, → READ. 1 (NACK) → WAIT_STOP.
- WAIT_STOP: `sda_oe`=0; only START (→ ADDR) or STOP (→ IDLE) leave it.
- STOP in any state → IDLE, `sda_oe`=0, `busy`=0; a partial byte is discarded and `rx_valid` does not pulse.
- Repeated START in any state → ADDR; a partial byte is discarded.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state IDLE, counter 0.
- Reset mid-transfer releases SDA on the cycle after `rst` is sampled high; no pulse outputs.
- Edge-detect latency: 3 `clk` from a raw pin transition to the internal event.
- `sda_oe` update: 1 `clk` after the internal SCL-fall event, so 4 `clk` after the raw SCL fall. This gives the data hold time on the bus.
- `rx_valid`: 1 `clk` after the internal 8th-rise event.
- `tx_data` setup: `tx_data` must be stable from `tx_req` + 1 `clk` until the next internal SCL-fall event, a minimum of ½ SCL period − 4 `clk`.
- Back-to-back: `rx_valid` and `tx_req` are never asserted in the same cycle.

## Configuration
- `IIC_TARGET_READ_EN` defined: READ and READ_ACK states, `tx_req` logic and `tx_data` capture are built; R/W=1 addresses are ACKed.
- Not defined: read path removed; `tx_req` tied 0; `tx_data` ignored; an address byte with R/W=1 is NACKed → WAIT_STOP, even if the address matches.

## Test plan
- Write 0x84, 0xAA, STOP at 100 kHz, clk 100 MHz → ACK driven on both 9th bits; `rx_data`=0xAA with exactly one `rx_valid`; `busy` 0 after STOP.
- Address 0x86 (7'h43, write) then 0x55 → SDA never pulled low; no `rx_valid`; `busy` stays 0.
- Read 0x85 with `tx_data`=0x5A, controller ACKs, second `tx_data`=0xC3, controller NACKs → SDA bits 01011010 then 11000011; exactly 2 `tx_req` pulses; SDA released after the NACK. Without `IIC_TARGET_READ_EN`: address NACKed and no `tx_req`.
- Write 0x84, 4 bits of 0xF0, repeated START, 0x84, 0x0F → only one `rx_valid`, with `rx_data`=0x0F.
- Assert `rst` for 1 cycle during the write ACK of 0x84 → `sda_oe`=0 the next cycle; the following bytes are ignored until a new START.
- STOP after 5 data bits of a write → state IDLE, no `rx_valid`, `rx_data` unchanged.
